writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Final pipeline stage, directly downstream of the memory-stage controller.
- Takes one decoded instruction per accept: ALU result, register-write controls, memory-write control and branch tag.
- Performs the data-memory access through a req/ack handshake and drives the two register-file write ports.
- Squashes instructions fetched on a stale branch path and back-pressures the upstream stage while a memory access is outstanding.

Parameters:
- ADDR_W, 8: data-memory word-address width.
- TIMEOUT, 15: maximum cycles in WAIT before the access is abandoned.
- LR_IDX, 14: register index used for link writes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream presents an instruction.
- ready_out  out  1  stage can accept this cycle.
- instr_in  in  32  instruction word, carried for debug.
- pc_in  in  7  instruction PC.
- branch_in  in  1  branch-reference tag of the instruction.
- branch_ref_global  in  1  current global branch reference.
- rd_in  in  4  destination register.
- rn_in  in  4  base register.
- sel_w_addr1_in  in  2  port-1 address select: 00=rd, 01=LR_IDX, 10=rn, 11=rd.
- w_en1_in  in  1  port-1 write request.
- mem_w_en_in  in  1  store.
- is_load_in  in  1  load.
- sel_pre_indexed_in  in  1  address source: 1=alu_result, 0=rn_val.
- alu_result_in  in  32  ALU output.
- rn_val_in  in  32  base register value.
- store_data_in  in  32  store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  ADDR_W  word address.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data.
- dmem_ack  in  1  request complete.
- w_addr1  out  4  register-file port-1 address.
- w_data1  out  32  port-1 data.
- w_en1  out  1  port-1 write enable.
- w_addr2  out  4  register-file port-2 address (load data).
- w_data2  out  32  port-2 data.
- w_en2  out  1  port-2 write enable.
- mem_err  out  1  sticky timeout flag.
- retired  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- Reset (rst high at posedge): state=IDLE, all outputs 0 except ready_out=1, timeout counter 0, mem_err cleared. Reset mid-access drops dmem_req the next cycle and discards the instruction with no register writes.
- States: IDLE, WAIT, WB.
- ready_out = (state==IDLE) | (state==WB).
- Accept occurs on a posedge with valid_in & ready_out. The instruction is squashed when branch_in != branch_ref_global at that edge.
  - Squashed: no memory access, no writes, no retired pulse, state→IDLE.
- Accept of a mem op (mem_w_en_in | is_load_in): register all fields, state→WAIT.
  - dmem_req=1 from the next cycle; dmem_we=mem_w_en_in.
  - dmem_addr = selected address [ADDR_W-1:0], selected per sel_pre_indexed_in.
  - dmem_wdata = store_data_in.
  - If both mem_w_en_in and is_load_in are 1, treat the instruction as a store.
- Accept of a non-mem instruction: state→WB directly, giving 1-cycle accept-to-write latency.
- WAIT:
  - dmem_req and dmem_we/addr/wdata stay stable until the cycle dmem_ack=1 is sampled. dmem_req drops the following cycle.
  - On ack, a load captures dmem_rdata; state→WB.
  - The counter increments each WAIT cycle without ack. When it reaches TIMEOUT, set mem_err (sticky until rst), suppress the load write, and go to WB.
  - An ack in the same cycle the counter reaches TIMEOUT counts as success.
- WB (exactly one cycle): w_en1/w_en2/retired are valid combinationally from the registered state.
  - w_en1 = w_en1_in (registered). w_addr1 per sel_w_addr1.
  - w_data1 = {25'b0, pc+1} when sel=01, else alu_result (the base writeback value for mem ops).
  - w_en2 = load & acked. w_addr2 = rd. w_data2 = captured rdata.
  - Conflict w_addr1==w_addr2 with both enabled: port 2 (load) wins, w_en1 forced 0.
  - retired=1.
  - A new accept in WB goes directly to WAIT or WB (back-to-back), giving a sustained 1/cycle rate for non-mem instructions.
- dmem_ack outside WAIT is ignored.
- pc+1 wraps modulo 128.

Decomposition:
- Shared package (pipeline_pkg):
  - state enum wb_state_t {IDLE, WAIT, WB};
  - sel_w_addr1 encodings (SEL_RD=2'b00, SEL_LR=2'b01, SEL_RN=2'b10);
  - LR_IDX default.
- Sub-module dmem_handshake: owns the WAIT state, the timeout counter, and the req/ack and error logic.
- Top module: accept/squash logic and the register-port writeback mux.

Test Plan:
- ADD result 0x0000_0005, rd=3, w_en1=1, tags match → next cycle w_en1=1, w_addr1=3, w_data1=5, retired=1, dmem_req never asserted.
- LDR rd=2, pre-indexed alu_result=0x10, ack after 3 cycles with rdata=0xDEAD_BEEF:
  - dmem_req high for 3 cycles with addr=0x10, ready_out=0 throughout;
  - then w_en2=1, w_addr2=2, w_data2=0xDEADBEEF.
- STR with writeback (sel=10, rn=4, alu_result=0x20, post-indexed rn_val=0x1C, ack in 1 cycle):
  - dmem_we=1, addr=0x1C, wdata=store_data;
  - then w_en1=1, w_addr1=4, w_data1=0x20, w_en2=0.
- branch_in=1 with branch_ref_global=0 on a STR → no dmem_req, no writes, no retired; the next valid instruction accepted immediately.
- LDR with no ack for TIMEOUT cycles → mem_err=1, WB with w_en2=0, retired=1. mem_err stays 1 until rst. A later LDR whose rd equals a port-1 writeback target is checked for port-2 priority.
- rst asserted during WAIT → the next cycle has dmem_req=0, ready_out=1, no register write; a following ADD completes normally.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the writeback stage.
//   wb_state_t     : writeback FSM states.
//   SEL_*          : encodings of the register-file port-1 address select.
//   LR_IDX_DEFAULT : register index written by link instructions.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    WB   = 2'd2
  } wb_state_t;

  localparam logic [1:0] SEL_RD = 2'b00;
  localparam logic [1:0] SEL_LR = 2'b01;
  localparam logic [1:0] SEL_RN = 2'b10;

  localparam int LR_IDX_DEFAULT = 14;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack engine for the writeback stage.
//   clk, rst                     : clock, synchronous active-high reset.
//   start, start_we/addr/wdata   : launch an access (one-cycle pulse).
//   dmem_req/we/addr/wdata       : memory request, held stable until ack.
//   dmem_rdata, dmem_ack         : memory response.
//   done                         : combinational, high in the last WAIT cycle
//                                  (ack seen or timeout reached).
//   acked, rdata                 : result of the finished access.
//   mem_err                      : sticky timeout flag, cleared only by rst.
module dmem_handshake #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [31:0]       start_wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              done,
  output logic              acked,
  output logic [31:0]       rdata,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value during the final permitted WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              acked_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              last_cycle;

  // req_q doubles as the "in WAIT" indication.
  assign last_cycle = (cnt_q == CNT_LAST);
  // An ack in the last permitted cycle still counts as success.
  assign done       = req_q & (dmem_ack | last_cycle);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      acked_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (start) begin
      req_q   <= 1'b1;
      we_q    <= start_we;
      addr_q  <= start_addr;
      wdata_q <= start_wdata;
      cnt_q   <= '0;
      acked_q <= 1'b0;
    end else if (req_q) begin
      if (dmem_ack) begin
        req_q   <= 1'b0;
        acked_q <= 1'b1;
        rdata_q <= dmem_rdata;
      end else if (last_cycle) begin
        req_q <= 1'b0;
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = req_q & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign acked      = acked_q;
  assign rdata      = rdata_q;
  assign mem_err    = err_q;

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: accepts one instruction per handshake, squashes
// stale-branch instructions, runs the data-memory access and drives the two
// register-file write ports for exactly one cycle (WB).
//   valid_in/ready_out          : upstream handshake.
//   instr_in .. store_data_in   : decoded instruction fields.
//   dmem_*                      : data-memory req/ack interface.
//   w_addr1/w_data1/w_en1       : port 1 (ALU result or link value).
//   w_addr2/w_data2/w_en2       : port 2 (load data).
//   mem_err                     : sticky memory timeout flag.
//   retired                     : one-cycle pulse per completed instruction.
module writeback_unit
  import pipeline_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int LR_IDX  = LR_IDX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [31:0]       instr_in,
  input  logic [6:0]        pc_in,
  input  logic              branch_in,
  input  logic              branch_ref_global,
  input  logic [3:0]        rd_in,
  input  logic [3:0]        rn_in,
  input  logic [1:0]        sel_w_addr1_in,
  input  logic              w_en1_in,
  input  logic              mem_w_en_in,
  input  logic              is_load_in,
  input  logic              sel_pre_indexed_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       rn_val_in,
  input  logic [31:0]       store_data_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [3:0]        w_addr1,
  output logic [31:0]       w_data1,
  output logic              w_en1,
  output logic [3:0]        w_addr2,
  output logic [31:0]       w_data2,
  output logic              w_en2,
  output logic              mem_err,
  output logic              retired
);

  localparam logic [3:0] LR_ADDR = 4'(LR_IDX);

  wb_state_t   state_q, state_n;
  logic        take, is_mem, hs_start, hs_done, hs_acked;
  logic [31:0] hs_rdata;
  logic [ADDR_W-1:0] start_addr;

  logic [6:0]  pc_q;
  logic [3:0]  rd_q, rn_q;
  logic [1:0]  sel_q;
  logic        wen1_q, load_q;
  logic [31:0] alu_q;

  // instr_in is carried for debug only; address bits above ADDR_W are unused.
  logic unused_bits;
  assign unused_bits = ^{instr_in, rn_val_in[31:ADDR_W]};

  assign ready_out  = (state_q == IDLE) | (state_q == WB);
  assign take       = valid_in & ready_out & (branch_in == branch_ref_global);
  assign is_mem     = mem_w_en_in | is_load_in;
  assign hs_start   = take & is_mem;
  assign start_addr = sel_pre_indexed_in ? alu_result_in[ADDR_W-1:0]
                                         : rn_val_in[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned (which would infer a latch).
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE, WB: begin
        if (take) state_n = is_mem ? WAIT : WB;
        else      state_n = IDLE;  // squashed or no request
      end
      WAIT:     if (hs_done) state_n = WB;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      rd_q   <= '0;
      rn_q   <= '0;
      sel_q  <= SEL_RD;
      wen1_q <= 1'b0;
      load_q <= 1'b0;
      alu_q  <= '0;
    end else if (take) begin
      pc_q   <= pc_in;
      rd_q   <= rd_in;
      rn_q   <= rn_in;
      sel_q  <= sel_w_addr1_in;
      wen1_q <= w_en1_in;
      load_q <= is_load_in & ~mem_w_en_in;  // store takes precedence
      alu_q  <= alu_result_in;
    end
  end

  dmem_handshake #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_hs (
    .clk         (clk),
    .rst         (rst),
    .start       (hs_start),
    .start_we    (mem_w_en_in),
    .start_addr  (start_addr),
    .start_wdata (store_data_in),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .done        (hs_done),
    .acked       (hs_acked),
    .rdata       (hs_rdata),
    .mem_err     (mem_err)
  );

  // Register-port writeback mux, live only in WB.
  always_comb begin
    logic       in_wb;
    logic [3:0] addr1_sel;
    in_wb = (state_q == WB);
    unique case (sel_q)
      SEL_LR:  addr1_sel = LR_ADDR;
      SEL_RN:  addr1_sel = rn_q;
      default: addr1_sel = rd_q;
    endcase
    w_en2   = in_wb & load_q & hs_acked;  // timed-out loads write nothing
    w_addr2 = w_en2 ? rd_q : 4'd0;
    w_data2 = w_en2 ? hs_rdata : 32'd0;
    // Same-register conflict: the load result on port 2 wins.
    w_en1   = in_wb & wen1_q & ~(w_en2 & (addr1_sel == rd_q));
    w_addr1 = in_wb ? addr1_sel : 4'd0;
    w_data1 = '0;
    if (in_wb) w_data1 = (sel_q == SEL_LR) ? {25'd0, pc_q + 7'd1} : alu_q;
    retired = in_wb;
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  typedef struct {
    logic [6:0]  pc;
    logic        br;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [1:0]  sel;
    logic        wen1;
    logic        store;
    logic        load;
    logic        pre;
    logic [31:0] alu;
    logic [31:0] rnv;
    logic [31:0] sdata;
  } op_t;

  typedef struct {
    logic        wen1;
    logic [3:0]  addr1;
    logic [31:0] data1;
    logic        wen2;
    logic [3:0]  addr2;
    logic [31:0] data2;
    logic        err;
  } exp_t;

  logic        clk, rst, valid_in, ready_out;
  logic [31:0] instr_in;
  logic [6:0]  pc_in;
  logic        branch_in, branch_ref_global;
  logic [3:0]  rd_in, rn_in;
  logic [1:0]  sel_w_addr1_in;
  logic        w_en1_in, mem_w_en_in, is_load_in, sel_pre_indexed_in;
  logic [31:0] alu_result_in, rn_val_in, store_data_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [3:0]  w_addr1, w_addr2;
  logic [31:0] w_data1, w_data2;
  logic        w_en1, w_en2, mem_err, retired;

  writeback_unit #(.ADDR_W(8), .TIMEOUT(15), .LR_IDX(14)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .instr_in(instr_in), .pc_in(pc_in), .branch_in(branch_in),
    .branch_ref_global(branch_ref_global), .rd_in(rd_in), .rn_in(rn_in),
    .sel_w_addr1_in(sel_w_addr1_in), .w_en1_in(w_en1_in),
    .mem_w_en_in(mem_w_en_in), .is_load_in(is_load_in),
    .sel_pre_indexed_in(sel_pre_indexed_in), .alu_result_in(alu_result_in),
    .rn_val_in(rn_val_in), .store_data_in(store_data_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .w_addr1(w_addr1), .w_data1(w_data1), .w_en1(w_en1),
    .w_addr2(w_addr2), .w_data2(w_data2), .w_en2(w_en2),
    .mem_err(mem_err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t op_zero();
    op_t o;
    o.pc = '0; o.br = 1'b0; o.rd = '0; o.rn = '0; o.sel = 2'b00;
    o.wen1 = 1'b0; o.store = 1'b0; o.load = 1'b0; o.pre = 1'b0;
    o.alu = '0; o.rnv = '0; o.sdata = '0;
    return o;
  endfunction

  function automatic exp_t ex(input logic wen1, input logic [3:0] a1, input logic [31:0] d1,
                              input logic wen2, input logic [3:0] a2, input logic [31:0] d2,
                              input logic err);
    exp_t e;
    e.wen1 = wen1; e.addr1 = a1; e.data1 = d1;
    e.wen2 = wen2; e.addr2 = a2; e.data2 = d2; e.err = err;
    return e;
  endfunction

  // Present one instruction for a single edge; it is accepted if ready_out.
  task automatic issue(input op_t o);
    instr_in = 32'hE000_0000 | {25'd0, o.pc};
    pc_in = o.pc; branch_in = o.br; rd_in = o.rd; rn_in = o.rn;
    sel_w_addr1_in = o.sel; w_en1_in = o.wen1; mem_w_en_in = o.store;
    is_load_in = o.load; sel_pre_indexed_in = o.pre; alu_result_in = o.alu;
    rn_val_in = o.rnv; store_data_in = o.sdata;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // Check n WAIT cycles of a held request, optionally acking in the last one,
  // then check the request has dropped in the WB cycle.
  task automatic wait_mem(input int n, input logic give_ack, input logic [31:0] rval,
                          input logic [7:0] exp_addr, input logic exp_we,
                          input logic [31:0] exp_wdata);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("req_held", 32'(dmem_req), 32'd1);
      check("ready_low_in_wait", 32'(ready_out), 32'd0);
      check("dmem_addr", 32'(dmem_addr), 32'(exp_addr));
      check("dmem_we", 32'(dmem_we), 32'(exp_we));
      if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
      if (give_ack && i == n - 1) begin
        dmem_ack = 1'b1;
        dmem_rdata = rval;
      end
    end
    @(posedge clk);
    #1 dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    @(negedge clk);
    check("req_dropped", 32'(dmem_req), 32'd0);
  endtask

  // Scoreboard monitor: every retire pops and compares one expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && retired === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_retire", 32'(retired), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("wb_en1", 32'(w_en1), 32'(e.wen1));
        if (e.wen1) begin
          check("wb_addr1", 32'(w_addr1), 32'(e.addr1));
          check("wb_data1", w_data1, e.data1);
        end
        check("wb_en2", 32'(w_en2), 32'(e.wen2));
        if (e.wen2) begin
          check("wb_addr2", 32'(w_addr2), 32'(e.addr2));
          check("wb_data2", w_data2, e.data2);
        end
        check("wb_mem_err", 32'(mem_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    rst = 1'b1; valid_in = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    branch_ref_global = 1'b0;
    instr_in = '0; pc_in = '0; branch_in = 1'b0; rd_in = '0; rn_in = '0;
    sel_w_addr1_in = '0; w_en1_in = 1'b0; mem_w_en_in = 1'b0; is_load_in = 1'b0;
    sel_pre_indexed_in = 1'b0; alu_result_in = '0; rn_val_in = '0; store_data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_en1", 32'(w_en1), 32'd0);
    check("rst_en2", 32'(w_en2), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    rst = 1'b0;

    // ADD r3 = 5
    o = op_zero(); o.pc = 7'd10; o.rd = 4'd3; o.wen1 = 1'b1; o.alu = 32'h5;
    sb_q.push_back(ex(1, 4'd3, 32'h5, 0, 0, 0, 0));
    issue(o);
    @(negedge clk);
    check("add_no_req", 32'(dmem_req), 32'd0);

    // LDR r2, pre-indexed 0x10, ack in 3rd cycle
    o = op_zero(); o.pc = 7'd11; o.rd = 4'd2; o.load = 1'b1; o.pre = 1'b1; o.alu = 32'h10;
    sb_q.push_back(ex(0, 0, 0, 1, 4'd2, 32'hDEAD_BEEF, 0));
    issue(o);
    wait_mem(3, 1'b1, 32'hDEAD_BEEF, 8'h10, 1'b0, 32'd0);

    // STR with base writeback to r4, post-indexed address 0x1C
    o = op_zero(); o.pc = 7'd12; o.rn = 4'd4; o.sel = 2'b10; o.wen1 = 1'b1;
    o.store = 1'b1; o.alu = 32'h20; o.rnv = 32'h1C; o.sdata = 32'hCAFE_F00D;
    sb_q.push_back(ex(1, 4'd4, 32'h20, 0, 0, 0, 0));
    issue(o);
    wait_mem(1, 1'b1, 32'h0, 8'h1C, 1'b1, 32'hCAFE_F00D);

    // Stale-branch STR is squashed
    o = op_zero(); o.br = 1'b1; o.store = 1'b1; o.wen1 = 1'b1; o.rnv = 32'h40;
    issue(o);
    @(negedge clk);
    check("squash_no_req", 32'(dmem_req), 32'd0);
    check("squash_no_retire", 32'(retired), 32'd0);
    check("squash_ready", 32'(ready_out), 32'd1);

    // Back-to-back: link write with pc wrap, then a plain ADD
    o = op_zero(); o.pc = 7'd127; o.sel = 2'b01; o.wen1 = 1'b1; o.alu = 32'h99;
    sb_q.push_back(ex(1, 4'd14, 32'h0, 0, 0, 0, 0));
    issue(o);
    o = op_zero(); o.pc = 7'd20; o.rd = 4'd9; o.sel = 2'b11; o.wen1 = 1'b1; o.alu = 32'hABCD;
    sb_q.push_back(ex(1, 4'd9, 32'hABCD, 0, 0, 0, 0));
    issue(o);
    @(negedge clk);
    // Stray ack while idle must be ignored
    dmem_ack = 1'b1;
    @(negedge clk);
    check("stray_ack_no_req", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b0;

    // LDR acked in the 15th (last) WAIT cycle still succeeds
    o = op_zero(); o.rd = 4'd5; o.load = 1'b1; o.pre = 1'b1; o.alu = 32'h44;
    sb_q.push_back(ex(0, 0, 0, 1, 4'd5, 32'h0F0F_0F0F, 0));
    issue(o);
    wait_mem(15, 1'b1, 32'h0F0F_0F0F, 8'h44, 1'b0, 32'd0);

    // LDR with no ack times out
    o = op_zero(); o.rd = 4'd8; o.load = 1'b1; o.rnv = 32'h7F;
    sb_q.push_back(ex(0, 0, 0, 0, 0, 0, 1));
    issue(o);
    wait_mem(15, 1'b0, 32'h0, 8'h7F, 1'b0, 32'd0);

    // Conflict: port 1 targets rd, load wins
    o = op_zero(); o.rd = 4'd6; o.wen1 = 1'b1; o.load = 1'b1; o.pre = 1'b1; o.alu = 32'h30;
    sb_q.push_back(ex(0, 0, 0, 1, 4'd6, 32'h1234_5678, 1));
    issue(o);
    wait_mem(2, 1'b1, 32'h1234_5678, 8'h30, 1'b0, 32'd0);

    // No conflict: base writeback to r7 alongside load into r6
    o = op_zero(); o.rd = 4'd6; o.rn = 4'd7; o.sel = 2'b10; o.wen1 = 1'b1;
    o.load = 1'b1; o.pre = 1'b1; o.alu = 32'h31;
    sb_q.push_back(ex(1, 4'd7, 32'h31, 1, 4'd6, 32'h55AA_55AA, 1));
    issue(o);
    wait_mem(1, 1'b1, 32'h55AA_55AA, 8'h31, 1'b0, 32'd0);

    // Reset during WAIT discards the access
    o = op_zero(); o.rd = 4'd1; o.wen1 = 1'b1; o.load = 1'b1; o.pre = 1'b1; o.alu = 32'h50;
    issue(o);
    @(negedge clk);
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req", 32'(dmem_req), 32'd0);
    check("midrst_ready", 32'(ready_out), 32'd1);
    check("midrst_en1", 32'(w_en1), 32'd0);
    check("midrst_en2", 32'(w_en2), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    check("midrst_err_cleared", 32'(mem_err), 32'd0);
    rst = 1'b0;

    o = op_zero(); o.rd = 4'd12; o.wen1 = 1'b1; o.alu = 32'h77;
    sb_q.push_back(ex(1, 4'd12, 32'h77, 0, 0, 0, 0));
    issue(o);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
